// File: rtl/general_lib.sv
// general_lib: definitions shared by the sync delay stage.
//   - FSM state encoding of the delay controller (IDLE / COUNT).
//   - Default widths for the programmable delay counter and the
//     saturating missed-sync counter.
package general_lib;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

  localparam int CTR_WIDTH_DEF  = 16;
  localparam int MISS_WIDTH_DEF = 8;

endpackage

// File: rtl/sync_delay_ctr_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears the count
//   clr    - synchronous clear, wins over a simultaneous increment
//   inc    - add one to the count unless it is already all-ones
//   count  - registered count value
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count register: clear first, then saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/sync_delay_ctr.sv
// sync_delay_ctr: programmable sync-pulse delay stage.
// A single-cycle sync strobe accepted in cycle k is re-emitted in cycle
// k+L, where L = delay_len (0 treated as 1). A down-counter FSM is used
// instead of a shift register, so long delays cost no storage. Strobes
// arriving while a delay is in flight are dropped and counted.
// Ports:
//   clk         - rising-edge clock
//   rst_n       - asynchronous active-low reset
//   en          - enable; low blocks acceptance and aborts an in-flight delay
//   sync_in     - incoming sync strobe
//   delay_len   - requested delay, sampled only when a sync is accepted
//   clr_missed  - synchronous clear of missed_cnt
//   sync_out    - delayed strobe, one cycle wide (registered)
//   busy        - high while a delay is in flight (registered)
//   missed_cnt  - saturating count of dropped strobes (registered)
module sync_delay_ctr
  import general_lib::*;
#(
  parameter int CTR_WIDTH  = CTR_WIDTH_DEF,
  parameter int MISS_WIDTH = MISS_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  sync_in,
  input  logic [CTR_WIDTH-1:0]  delay_len,
  input  logic                  clr_missed,
  output logic                  sync_out,
  output logic                  busy,
  output logic [MISS_WIDTH-1:0] missed_cnt
);

  logic [0:0]           state;
  logic [CTR_WIDTH-1:0] counter;
  logic                 accept;
  logic                 miss;
  logic                 short_delay;

  // Acceptance / drop decode; delays of 0 and 1 both complete from IDLE.
  always_comb begin
    accept      = sync_in && en && (state == ST_IDLE);
    miss        = sync_in && (state == ST_COUNT);
    short_delay = (delay_len <= CTR_WIDTH'(1));
  end

  // Delay FSM and down-counter. The counter is loaded with L-2 because the
  // load edge and the exit edge each account for one cycle of the delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      counter  <= '0;
      sync_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      sync_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && short_delay) begin
            sync_out <= 1'b1;
          end else if (accept) begin
            state   <= ST_COUNT;
            busy    <= 1'b1;
            counter <= delay_len - CTR_WIDTH'(2);
          end else begin
            busy    <= 1'b0;
          end
        end
        ST_COUNT: begin
          if (!en) begin
            // Abort: the pending strobe is discarded.
            state   <= ST_IDLE;
            busy    <= 1'b0;
            counter <= '0;
          end else if (counter == '0) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            sync_out <= 1'b1;
          end else begin
            counter <= counter - CTR_WIDTH'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          counter <= '0;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (MISS_WIDTH)
  ) u_missed (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_missed),
    .inc   (miss),
    .count (missed_cnt)
  );

endmodule

// File: tb/tb_sync_delay_ctr.sv
// Self-checking bench for sync_delay_ctr. Two instances share stimulus:
// the default configuration and one with a 2-bit missed counter. A
// cycle-number model (due cycle of the pending strobe) predicts all
// outputs every cycle; literal checks pin specific scenarios.
module tb_sync_delay_ctr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sync_in;
  logic [15:0] delay_len;
  logic        clr_missed;
  logic        sync_out, busy;
  logic [7:0]  missed_cnt;
  logic        sync_out2, busy2;
  logic [1:0]  missed_cnt2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int due_cyc = -1;
  int m_miss = 0;
  int m_miss2 = 0;
  int out_cnt = 0;
  int busy_cnt = 0;
  int last_out_cyc = -1;
  int s0, o0;

  always #5 clk = ~clk;

  sync_delay_ctr dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_in(sync_in),
    .delay_len(delay_len), .clr_missed(clr_missed),
    .sync_out(sync_out), .busy(busy), .missed_cnt(missed_cnt)
  );

  sync_delay_ctr #(.CTR_WIDTH(16), .MISS_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_in(sync_in),
    .delay_len(delay_len), .clr_missed(clr_missed),
    .sync_out(sync_out2), .busy(busy2), .missed_cnt(missed_cnt2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle: apply inputs, advance the model at the edge, compare.
  task automatic step(input logic s, input logic e, input logic [15:0] dl, input logic c);
    logic busy_k;
    logic miss_k;
    int   len;
    sync_in = s; en = e; delay_len = dl; clr_missed = c;
    @(posedge clk);
    busy_k = (due_cyc > cyc);
    miss_k = s && busy_k;
    if (busy_k && !e) begin
      due_cyc = -1;
    end else if (s && e && !busy_k) begin
      len = (dl == 16'd0) ? 1 : int'(dl);
      due_cyc = cyc + len;
    end
    if (c) begin
      m_miss = 0; m_miss2 = 0;
    end else if (miss_k) begin
      m_miss  = (m_miss  < 255) ? m_miss + 1  : 255;
      m_miss2 = (m_miss2 < 3)   ? m_miss2 + 1 : 3;
    end
    cyc++;
    #1;
    chk("sync_out",    int'(sync_out),    (due_cyc == cyc) ? 1 : 0);
    chk("busy",        int'(busy),        (due_cyc > cyc) ? 1 : 0);
    chk("missed_cnt",  int'(missed_cnt),  m_miss);
    chk("sync_out2",   int'(sync_out2),   (due_cyc == cyc) ? 1 : 0);
    chk("busy2",       int'(busy2),       (due_cyc > cyc) ? 1 : 0);
    chk("missed_cnt2", int'(missed_cnt2), m_miss2);
    if (sync_out) begin
      out_cnt++;
      last_out_cyc = cyc;
    end
    if (busy) busy_cnt++;
  endtask

  task automatic idle(input int n, input logic [15:0] dl);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, dl, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sync_in = 1'b0; delay_len = 16'd0; clr_missed = 1'b0;
    #1;
    chk("reset_sync_out", int'(sync_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_missed", int'(missed_cnt), 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0; due_cyc = -1;

    // Delay 5, sync at cycle 10; delay_len changed while counting.
    while (cyc < 10) step(1'b0, 1'b1, 16'd5, 1'b0);
    step(1'b1, 1'b1, 16'd5, 1'b0);
    idle(10, 16'd3);
    chk("t1_out_cycle", last_out_cyc, 15);
    chk("t1_busy_cycles", busy_cnt, 4);
    chk("t1_out_count", out_cnt, 1);
    chk("t1_missed", int'(missed_cnt), 0);

    // Delay 0 and delay 1 both give a one-cycle latency, never busy.
    s0 = cyc; step(1'b1, 1'b1, 16'd0, 1'b0); idle(3, 16'd0);
    chk("t2_len0_latency", last_out_cyc - s0, 1);
    s0 = cyc; step(1'b1, 1'b1, 16'd1, 1'b0); idle(3, 16'd1);
    chk("t2_len1_latency", last_out_cyc - s0, 1);
    chk("t2_busy_cycles", busy_cnt, 4);

    // Period-4 sync train with delay 4: no drops.
    o0 = out_cnt;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 16'd4, 1'b0);
      idle(3, 16'd4);
    end
    idle(2, 16'd4);
    chk("t3_out_count", out_cnt - o0, 8);
    chk("t3_missed", int'(missed_cnt), 0);

    // Delay 10 with syncs at 0, 3, 6: one output, two misses.
    s0 = cyc;
    step(1'b1, 1'b1, 16'd10, 1'b0); idle(2, 16'd10);
    step(1'b1, 1'b1, 16'd10, 1'b0); idle(2, 16'd10);
    step(1'b1, 1'b1, 16'd10, 1'b0); idle(6, 16'd10);
    chk("t4_out_offset", last_out_cyc - s0, 10);
    chk("t4_missed", int'(missed_cnt), 2);
    // Clear together with a miss: clear wins.
    step(1'b1, 1'b1, 16'd10, 1'b0);
    step(1'b1, 1'b1, 16'd10, 1'b1);
    chk("t4_clr_priority", int'(missed_cnt), 0);
    idle(12, 16'd10);

    // Sync held high 8 cycles with delay 20: 7 misses, narrow counter saturates.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'd20, 1'b0);
    chk("t5_missed_sat", int'(missed_cnt2), 3);
    chk("t5_missed_wide", int'(missed_cnt), 7);
    idle(16, 16'd20);
    step(1'b0, 1'b1, 16'd20, 1'b1);
    chk("t5_cleared", int'(missed_cnt), 0);

    // en dropped at cycle 4 of a delay-8 run: busy falls at 5, no output.
    o0 = out_cnt;
    step(1'b1, 1'b1, 16'd8, 1'b0);
    idle(3, 16'd8);
    chk("t6_busy_before_abort", int'(busy), 1);
    step(1'b0, 1'b0, 16'd8, 1'b0);
    chk("t6_busy_after_abort", int'(busy), 0);
    idle(8, 16'd8);
    chk("t6_no_output", out_cnt - o0, 0);

    // Asynchronous reset mid-count: outputs clear immediately.
    o0 = out_cnt;
    step(1'b1, 1'b1, 16'd8, 1'b0);
    step(1'b1, 1'b1, 16'd8, 1'b0);
    idle(2, 16'd8);
    chk("t7_busy_pre_reset", int'(busy), 1);
    chk("t7_missed_pre_reset", int'(missed_cnt), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_sync_out", int'(sync_out), 0);
    chk("t7_rst_busy", int'(busy), 0);
    chk("t7_rst_missed", int'(missed_cnt), 0);
    chk("t7_rst_busy2", int'(busy2), 0);
    due_cyc = -1; m_miss = 0; m_miss2 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(12, 16'd8);
    chk("t7_no_output", out_cnt - o0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
